// File: rtl/jk_ff_pkg.sv
// jk_ff_pkg: shared encoding for the JK flip-flop family.
//   jk_op_e - the {j,k} pair read as an operation (hold/reset/set/toggle).
package jk_ff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

endpackage

// File: rtl/jk_ff_cell.sv
// jk_cell: single-bit JK flip-flop with clock enable and async active-low clear.
//   clk    - rising-edge clock
//   clr    - async active-low clear, forces q to RESET_VALUE
//   enable - synchronous enable, 0 holds the bit
//   j, k   - set / reset inputs (both high toggles)
//   q      - stored bit
module jk_cell
  import jk_ff_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic enable,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (enable) begin
      case (jk_op_e'({j, k}))
        JK_HOLD:   q_d = q_q;
        JK_RESET:  q_d = 1'b0;
        JK_SET:    q_d = 1'b1;
        JK_TOGGLE: q_d = ~q_q;
        default:   q_d = q_q;
      endcase
    end
  end

  // Clear is purely asynchronous: while clr is low the clock edge is ignored,
  // so nothing sampled during clear survives its release.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_ff.sv
// jk_ff: WIDTH independent JK flip-flops sharing clk, clr and enable.
//   q      - stored state (WIDTH)
//   qbar   - combinational complement of q (WIDTH)
//   clk    - rising-edge clock
//   clr    - async active-low clear, q = RESET_VALUE while low
//   enable - synchronous enable, 0 holds every bit
//   j, k   - per-bit set / reset inputs (WIDTH)
module jk_ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_cell (
      .clk   (clk),
      .clr   (clr),
      .enable(enable),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

  // qbar is derived, not stored, so it can never disagree with q.
  assign qbar = ~q;

endmodule

// File: tb/tb_jk_ff.sv
module tb_jk_ff;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // single-bit DUT
  logic       clr, enable, j, k;
  logic [0:0] q, qbar;

  // 4-bit DUT with non-zero reset value
  logic       clr4, enable4;
  logic [3:0] j4, k4, q4, qbar4;

  // ripple chain
  logic       clr_r;
  logic [0:0] rq0, rqb0, rq1, rqb1, rq2, rqb2;

  jk_ff dut (
    .q(q), .qbar(qbar), .clk(clk), .clr(clr), .enable(enable), .j(j), .k(k)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b0101)) dut4 (
    .q(q4), .qbar(qbar4), .clk(clk), .clr(clr4), .enable(enable4), .j(j4), .k(k4)
  );

  jk_ff r0 (.q(rq0), .qbar(rqb0), .clk(clk),     .clr(clr_r), .enable(1'b1), .j(1'b1), .k(1'b1));
  jk_ff r1 (.q(rq1), .qbar(rqb1), .clk(rqb0[0]), .clr(clr_r), .enable(1'b1), .j(1'b1), .k(1'b1));
  jk_ff r2 (.q(rq2), .qbar(rqb2), .clk(rqb1[0]), .clr(clr_r), .enable(1'b1), .j(1'b1), .k(1'b1));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; enable = 1'b1; j = 1'bx; k = 1'bx;
    clr4 = 1'b0; enable4 = 1'b0; j4 = 4'bxxxx; k4 = 4'bxxxx;
    clr_r = 1'b0;

    // Reset held through 50 ns with changing (initially X) j/k.
    for (int t = 0; t <= 51; t++) begin
      if (t == 5)  begin j = 1'b0; k = 1'b1; end
      if (t == 8)  begin j = 1'b0; k = 1'b0; end
      if (t == 18) begin j = 1'b1; k = 1'b0; end
      if (t == 28) begin j = 1'b1; k = 1'b1; end
      if (t % 4 == 3) begin
        chk("rst_q",     {3'b0, q},    4'b0000);
        chk("rst_qbar",  {3'b0, qbar}, 4'b0001);
        chk("rst4_q",    q4,           4'b0101);
        chk("rst4_qbar", qbar4,        4'b1010);
        chk("rst_chain", {1'b0, rq2, rq1, rq0}, 4'b0000);
      end
      if (t < 51) #1;
    end

    // t=51: one ns after an edge; release clear mid-cycle.
    clr = 1'b1; j = 1'b1; k = 1'b0;
    step(); chk("set_q", {3'b0, q}, 4'b0001); chk("set_qbar", {3'b0, qbar}, 4'b0000);
    j = 1'b0; k = 1'b0;
    step(); chk("hold_q", {3'b0, q}, 4'b0001);
    j = 1'b0; k = 1'b1;
    step(); chk("reset_q", {3'b0, q}, 4'b0000); chk("reset_qbar", {3'b0, qbar}, 4'b0001);
    j = 1'b1; k = 1'b1;
    step(); chk("tog1_q", {3'b0, q}, 4'b0001); chk("tog1_qbar", {3'b0, qbar}, 4'b0000);
    step(); chk("tog2_q", {3'b0, q}, 4'b0000); chk("tog2_qbar", {3'b0, qbar}, 4'b0001);
    step(); chk("tog3_q", {3'b0, q}, 4'b0001); chk("tog3_qbar", {3'b0, qbar}, 4'b0000);
    step(); chk("tog4_q", {3'b0, q}, 4'b0000); chk("tog4_qbar", {3'b0, qbar}, 4'b0001);

    // Enable low holds q=0 despite j=1.
    enable = 1'b0; j = 1'b1; k = 1'b0;
    step(); chk("en0_a", {3'b0, q}, 4'b0000);
    step(); chk("en0_b", {3'b0, q}, 4'b0000);
    step(); chk("en0_c", {3'b0, q}, 4'b0000);
    enable = 1'b1;
    step(); chk("en1_q", {3'b0, q}, 4'b0001);

    // Async clear mid-cycle, no edge between assertion and check.
    #1 clr = 1'b0;
    #1;
    chk("aclr_q",    {3'b0, q},    4'b0000);
    chk("aclr_qbar", {3'b0, qbar}, 4'b0001);
    j = 1'b1; k = 1'b0;
    // Release after the edge's own evaluation in the same time step.
    @(posedge clk);
    #0 clr = 1'b1;
    #1;
    chk("rel_edge_q", {3'b0, q}, 4'b0000);
    step(); chk("rel_next_q", {3'b0, q}, 4'b0001);

    // 4-bit instance: toggle all bits from the 0101 reset value.
    clr4 = 1'b1; enable4 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
    step(); chk("w4_q", q4, 4'b1010); chk("w4_qbar", qbar4, 4'b0101);
    j4 = 4'b0011; k4 = 4'b0110;  // bits: hold, reset, toggle, set
    step(); chk("w4_mix_q", q4, 4'b1001); chk("w4_mix_qbar", qbar4, 4'b0110);

    // Ripple counter: counts up 1..7 then wraps to 0 and 1.
    clr_r = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      chk($sformatf("chain_%0d", n), {1'b0, rq2, rq1, rq0}, 4'(n % 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout: got running expected done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
